seg_msg_arbiter: RTL and testbench

//   Shares the 8-digit seg_value/seg_en display path between the always-valid state

---
 rtl/seg_msg_arbiter.sv | 162 ++++++++++++++++
 tb/tb_seg_msg_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg_msg_arbiter.sv
// Arbitrates the 8-digit display between a base state display and two round-robin message requesters.
// Optional blink of the granted message is enabled by defining SEG_ARB_BLINK_EN.
module seg_msg_arbiter #(
  parameter int HOLD_CYC   = 1000,
  parameter int BLINK_HALF = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] base_value,
  input  logic [7:0]  base_en,
  input  logic        msg0_req,
  input  logic [31:0] msg0_value,
  input  logic [7:0]  msg0_en,
  output logic        msg0_ack,
  input  logic        msg1_req,
  input  logic [31:0] msg1_value,
  input  logic [7:0]  msg1_en,
  output logic        msg1_ack,
  output logic [31:0] seg_value,
  output logic [7:0]  seg_en,
  output logic        busy,
  output logic        grant_id
);

  localparam int CW = $clog2(HOLD_CYC);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state_q, state_d;
  logic [31:0]   seg_value_q, seg_value_d;
  logic [7:0]    seg_en_q, seg_en_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic          grant_id_q, grant_id_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   msg_value_q, msg_value_d;
  logic [7:0]    msg_en_q, msg_en_d;
  logic          win;

`ifdef SEG_ARB_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF + 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
`endif

  always_comb begin
    state_d      = state_q;
    seg_value_d  = seg_value_q;
    seg_en_d     = seg_en_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    busy_d       = busy_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    msg_value_d  = msg_value_q;
    msg_en_d     = msg_en_q;
`ifdef SEG_ARB_BLINK_EN
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
`endif
    // On a tie the requester that did not win last time gets the display.
    win = (msg0_req && msg1_req) ? ~last_grant_q : msg1_req;

    case (state_q)
      IDLE: begin
        seg_value_d = base_value;
        seg_en_d    = base_en;
        if (msg0_req || msg1_req) begin
          state_d      = SHOW;
          ack0_d       = ~win;
          ack1_d       = win;
          msg_value_d  = win ? msg1_value : msg0_value;
          msg_en_d     = win ? msg1_en : msg0_en;
          seg_value_d  = msg_value_d;
          seg_en_d     = msg_en_d;
          grant_id_d   = win;
          last_grant_d = win;
          busy_d       = 1'b1;
          cnt_d        = CW'(HOLD_CYC - 1);
`ifdef SEG_ARB_BLINK_EN
          blink_cnt_d  = BW'(BLINK_HALF - 1);
          blink_on_d   = 1'b1;
`endif
        end
      end
      SHOW: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          seg_value_d = base_value;
          seg_en_d    = base_en;
        end else begin
          cnt_d       = cnt_q - 1'b1;
          seg_value_d = msg_value_q;
`ifdef SEG_ARB_BLINK_EN
          if (blink_cnt_q == '0) begin
            blink_on_d  = ~blink_on_q;
            blink_cnt_d = BW'(BLINK_HALF - 1);
          end else begin
            blink_cnt_d = blink_cnt_q - 1'b1;
          end
          seg_en_d = blink_on_d ? msg_en_q : 8'h00;
`else
          seg_en_d = msg_en_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      seg_value_q  <= 32'h0;
      seg_en_q     <= 8'h00;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      msg_value_q  <= 32'h0;
      msg_en_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      seg_value_q  <= seg_value_d;
      seg_en_q     <= seg_en_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      msg_value_q  <= msg_value_d;
      msg_en_q     <= msg_en_d;
    end
  end

`ifdef SEG_ARB_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`endif

  assign seg_value = seg_value_q;
  assign seg_en    = seg_en_q;
  assign msg0_ack  = ack0_q;
  assign msg1_ack  = ack1_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_seg_msg_arbiter.sv
// Randomised and directed bench for seg_msg_arbiter against a display-timeline reference model.
module tb_seg_msg_arbiter;
  localparam int H = 16;
  localparam int B = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] base_value = 32'h0;
  logic [7:0]  base_en = 8'h00;
  logic        mreq [0:1];
  logic [31:0] mval [0:1];
  logic [7:0]  men  [0:1];
  logic        msg0_ack, msg1_ack, busy, grant_id;
  logic [31:0] seg_value;
  logic [7:0]  seg_en;

  seg_msg_arbiter #(.HOLD_CYC(H), .BLINK_HALF(B)) dut (
    .clk(clk), .rst(rst),
    .base_value(base_value), .base_en(base_en),
    .msg0_req(mreq[0]), .msg0_value(mval[0]), .msg0_en(men[0]), .msg0_ack(msg0_ack),
    .msg1_req(mreq[1]), .msg1_value(mval[1]), .msg1_en(men[1]), .msg1_ack(msg1_ack),
    .seg_value(seg_value), .seg_en(seg_en), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference: message on screen for H cycles after its grant, then base again.
  bit          m_show;
  int          m_left, m_age;
  bit          m_last, m_id, m_ack0, m_ack1;
  logic [31:0] m_val, exp_val;
  logic [7:0]  m_en, exp_en;
  int          ack_order[$];
  logic [31:0] track_val;
  int          track_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_show = 0; m_left = 0; m_age = 0; m_last = 1; m_id = 0;
    m_ack0 = 0; m_ack1 = 0; m_val = 0; m_en = 0; exp_val = 0; exp_en = 0;
  endtask

  task automatic model_edge();
    bit w;
    m_ack0 = 0; m_ack1 = 0;
    if (!m_show) begin
      if (mreq[0] || mreq[1]) begin
        w = (mreq[0] && mreq[1]) ? !m_last : mreq[1];
        m_show = 1; m_left = H; m_age = 0;
        m_val = mval[w]; m_en = men[w];
        m_id = w; m_last = w;
        if (w) m_ack1 = 1; else m_ack0 = 1;
        exp_val = m_val; exp_en = m_en;
        $display("grant id=%0d value=%h en=%h t=%0t", w, m_val, m_en, $time);
      end else begin
        exp_val = base_value; exp_en = base_en;
      end
    end else begin
      m_left--; m_age++;
      if (m_left == 0) begin
        m_show = 0;
        exp_val = base_value; exp_en = base_en;
      end else begin
        exp_val = m_val;
`ifdef SEG_ARB_BLINK_EN
        exp_en = ((m_age / B) % 2 == 0) ? m_en : 8'h00;
`else
        exp_en = m_en;
`endif
      end
    end
  endtask

  task automatic compare_all();
    check_val("seg_value", seg_value, exp_val);
    check_val("seg_en", {24'h0, seg_en}, {24'h0, exp_en});
    check_val("busy", {31'h0, busy}, {31'h0, m_show});
    check_val("grant_id", {31'h0, grant_id}, {31'h0, m_id});
    check_val("ack0", {31'h0, msg0_ack}, {31'h0, m_ack0});
    check_val("ack1", {31'h0, msg1_ack}, {31'h0, m_ack1});
    check_val("both_acks", {31'h0, msg0_ack & msg1_ack}, 32'h0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
    compare_all();
    if (msg0_ack) ack_order.push_back(0);
    if (msg1_ack) ack_order.push_back(1);
    if (seg_value === track_val) track_cnt++;
  endtask

  // Requesters drop req after their ack unless keep is set.
  task automatic run(input int n, input bit keep);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (msg0_ack && !keep) mreq[0] = 0;
      if (msg1_ack && !keep) mreq[1] = 0;
    end
  endtask

  task automatic pulse_reset();
    rst = 1;
    #1;
    model_reset();
    compare_all();
    cycle();
    rst = 0;
  endtask

  initial begin
    int got;
    mreq[0] = 0; mreq[1] = 0;
    mval[0] = 0; mval[1] = 0; men[0] = 0; men[1] = 0;
    track_val = 32'hDEAD_BEEF; track_cnt = 0;
    model_reset();
    #1;
    compare_all();
    run(2, 0);

    // Tie held from reset: expect grants 0,1,0
    mreq[0] = 1; mreq[1] = 1;
    mval[0] = 32'hA000_0000; men[0] = 8'h80;
    mval[1] = 32'hB000_0000; men[1] = 8'h40;
    base_value = 32'h1234_5678; base_en = 8'hFF;
    rst = 0;
    ack_order.delete();
    run(3 * (H + 1), 1);
    mreq[0] = 0; mreq[1] = 0;
    for (int k = 0; k < 3; k++) begin
      got = (ack_order.size() > k) ? ack_order[k] : 7;
      check_val($sformatf("tie_order%0d", k), got, (k == 1) ? 1 : 0);
    end
    run(H + 2, 0);

    // Single message with exact hold length; value changed after ack stays latched
    base_value = 32'h1000_0000; base_en = 8'h80;
    mval[0] = 32'hE000_0000; men[0] = 8'h80; mreq[0] = 1;
    track_val = 32'hE000_0000; track_cnt = 0;
    run(1, 0);
    mval[0] = 32'h5555_5555;
    run(H + 3, 0);
    check_val("hold_len", track_cnt, H);
    track_val = 32'hDEAD_BEEF;

    // Withdraw: req1 pulsed during msg0's SHOW is never granted
    mval[0] = 32'hC000_0001; men[0] = 8'h0F; mreq[0] = 1;
    ack_order.delete();
    run(3, 0);
    mreq[1] = 1; mval[1] = 32'h7777_7777; men[1] = 8'hF0;
    run(1, 0);
    mreq[1] = 0;
    run(H + 2, 0);
    check_val("withdraw_acks", ack_order.size(), 1);

    // Reset in the middle of SHOW
    mreq[0] = 1;
    run(5, 0);
    pulse_reset();
    run(H + 2, 0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      cycle();
      for (int i = 0; i < 2; i++) begin
        if (mreq[i] && ((i == 0) ? msg0_ack : msg1_ack)) begin
          mreq[i] = ($urandom % 4 == 0);
          mval[i] = $urandom; men[i] = 8'($urandom);
        end else if (mreq[i]) begin
          if ($urandom % 20 == 0) mreq[i] = 0;
          if ($urandom % 3 == 0) mval[i] = $urandom;
        end else if ($urandom % 6 == 0) begin
          mreq[i] = 1; mval[i] = $urandom; men[i] = 8'($urandom);
        end
      end
      if ($urandom % 4 == 0) begin
        base_value = $urandom; base_en = 8'($urandom);
      end
      if ($urandom % 700 == 0) pulse_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
